// File: rtl/mvm_pkg.sv
// Shared widths, tag sizing and arbiter state for the MVM job scheduler.
// Widths are derived from the matrix geometry chosen by the top-level parameters.
package mvm_pkg;

  localparam int R_DEF   = 8;
  localparam int C_DEF   = 8;
  localparam int W_X_DEF = 8;
  localparam int W_K_DEF = 8;

  localparam int W_Y      = W_X_DEF + W_K_DEF + $clog2(C_DEF);
  localparam int W_BUS_KX = R_DEF * C_DEF * W_K_DEF + C_DEF * W_X_DEF;
  localparam int W_BUS_Y  = R_DEF * W_Y;

  typedef enum logic {IDLE, HOLD} arb_state_e;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int w_y(input int wx, input int wk, input int c);
    return wx + wk + $clog2(c);
  endfunction

  function automatic int w_bus_kx(input int r, input int c,
                                  input int wk, input int wx);
    return r * c * wk + c * wx;
  endfunction

endpackage

// File: rtl/mvm_tag_fifo.sv
// In-order owner-tag FIFO for jobs issued to the shared datapath.
// Same-cycle push and pop are legal; DEPTH must be a power of two.
module mvm_tag_fifo
  import mvm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mvm_job_scheduler.sv
// Round-robin sharing of one matvec datapath between NUM_REQ requesters.
// Optional per-requester response counters: define MVM_SCHED_STATS_EN.
module mvm_job_scheduler
  import mvm_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int R            = 8,
  parameter int C            = 8,
  parameter int W_X          = 8,
  parameter int W_K          = 8,
  parameter int MAX_INFLIGHT = 4,
  localparam int WY  = w_y(W_X, W_K, C),
  localparam int WKX = w_bus_kx(R, C, W_K, W_X),
  localparam int WBY = R * WY,
  localparam int TW  = tag_w(NUM_REQ),
  localparam int CW  = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     s_req_tvalid,
  output logic [NUM_REQ-1:0]     s_req_tready,
  input  logic [NUM_REQ*WKX-1:0] s_req_tdata,
  output logic                   mvm_kx_tvalid,
  input  logic                   mvm_kx_tready,
  output logic [WKX-1:0]         mvm_kx_tdata,
  input  logic                   mvm_y_tvalid,
  output logic                   mvm_y_tready,
  input  logic [WBY-1:0]         mvm_y_tdata,
  output logic [NUM_REQ-1:0]     m_rsp_tvalid,
  input  logic [NUM_REQ-1:0]     m_rsp_tready,
  output logic [WBY-1:0]         m_rsp_tdata,
  output logic [CW-1:0]          inflight,
  output logic                   err_orphan
`ifdef MVM_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  job_done
`endif
);

  arb_state_e    state_q, state_d;
  logic [TW-1:0] gnt_q, gnt_d;
  logic [TW-1:0] rr_q, rr_d;
  logic [TW-1:0] pick, head;
  logic          found;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  int            idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!found && s_req_tvalid[idx]) begin
        found = 1'b1;
        pick  = TW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  // gnt stays frozen in HOLD so the offered bus is stable while valid
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_d          = rr_q;
    push          = 1'b0;
    mvm_kx_tvalid = 1'b0;
    s_req_tready  = '0;
    unique case (state_q)
      IDLE: begin
        if (!full && found) begin
          gnt_d   = pick;
          state_d = HOLD;
        end
      end
      HOLD: begin
        mvm_kx_tvalid       = 1'b1;
        s_req_tready[gnt_q] = mvm_kx_tready;
        if (mvm_kx_tready) begin
          push    = 1'b1;
          rr_d    = TW'((int'(gnt_q) + 1) % NUM_REQ);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mvm_kx_tdata = s_req_tdata[int'(gnt_q)*WKX +: WKX];

  mvm_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (TW)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (gnt_q),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    m_rsp_tvalid       = '0;
    m_rsp_tvalid[head] = mvm_y_tvalid & ~empty;
    mvm_y_tready       = ~empty & m_rsp_tready[head];
  end

  assign pop         = mvm_y_tvalid & mvm_y_tready;
  assign m_rsp_tdata = mvm_y_tdata;
  assign inflight    = count;

  // a result with no recorded owner cannot be routed
  always_ff @(posedge clk) begin
    if (rst)                        err_orphan <= 1'b0;
    else if (mvm_y_tvalid && empty) err_orphan <= 1'b1;
  end

`ifdef MVM_SCHED_STATS_EN
  logic [15:0] done_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) done_q[i] <= '0;
    end else if (pop && done_q[head] != 16'hFFFF) begin
      done_q[head] <= done_q[head] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_done
    assign job_done[g*16 +: 16] = done_q[g];
  end
`endif

endmodule
